// File: rtl/ct_idu_rf_ereg_ctrl.sv
// ct_idu_rf_ereg_ctrl
//   Lifecycle controller for the gated 6-bit vector extended registers (eregs)
//   of the IDU register file. Each entry moves FREE -> ALLOC -> WB -> RET -> FREE.
//   The block drives the per-entry writeback strobes and RET flags to the eregs,
//   and folds the values of released entries into a sticky 6-bit accumulator
//   for the CSR path.
//
//   Optional build macro: CT_IDU_EREG_ERR_CHK_EN
//     When defined, adds the sticky output ereg_proto_err. It flags any illegal
//     event that the controller otherwise ignores silently.
//
//   state | meaning
//   FREE  | entry is in the free pool
//   ALLOC | entry renamed to an instruction, data not yet written
//   WB    | data written by pipe6 or pipe7, owner not yet retired
//   RET   | owner retired, entry drives its value until released
module ct_idu_rf_ereg_ctrl #(
  parameter int NUM   = 16,
  parameter int IDX_W = 4
) (
  input  logic                 ereg_clk,
  input  logic                 cpurst_b,
  input  logic                 alloc_vld,
  input  logic [IDX_W-1:0]     alloc_idx,
  input  logic                 pipe6_wb_vld,
  input  logic [IDX_W-1:0]     pipe6_wb_idx,
  input  logic                 pipe7_wb_vld,
  input  logic [IDX_W-1:0]     pipe7_wb_idx,
  input  logic                 retire_vld,
  input  logic [IDX_W-1:0]     retire_idx,
  input  logic                 release_vld,
  input  logic [IDX_W-1:0]     release_idx,
  input  logic                 flush_vld,
  input  logic                 acc_clr_vld,
  input  logic [6*NUM-1:0]     ereg_acc_dout,
  output logic [2*NUM-1:0]     x_wb_vld,
  output logic [NUM-1:0]       x_retired_released_wb,
  output logic [NUM-1:0]       free_vec,
  output logic [IDX_W:0]       free_cnt,
`ifdef CT_IDU_EREG_ERR_CHK_EN
  output logic                 ereg_proto_err,
`endif
  output logic [5:0]           acc_value
);

  typedef enum logic [1:0] {
    FREE  = 2'b00,
    ALLOC = 2'b01,
    WB    = 2'b10,
    RET   = 2'b11
  } ereg_state_e;

  ereg_state_e st_q [NUM];
  ereg_state_e st_d [NUM];

  logic [NUM-1:0] alloc_hit;
  logic [NUM-1:0] wb6_raw;
  logic [NUM-1:0] wb7_raw;
  logic [NUM-1:0] wb6_hit;
  logic [NUM-1:0] wb7_hit;
  logic [NUM-1:0] retire_hit;
  logic [NUM-1:0] release_hit;

  logic [5:0]     sticky_q;
  logic [5:0]     fold;
  logic [5:0]     dout_or;

  // Decode every request index into a per-entry hit vector.
  // Writeback strobes only reach live entries and are killed by a flush;
  // pipe6 has priority when both pipes target the same entry.
  always_comb begin
    alloc_hit   = '0;
    wb6_raw     = '0;
    wb7_raw     = '0;
    wb6_hit     = '0;
    wb7_hit     = '0;
    retire_hit  = '0;
    release_hit = '0;
    for (int i = 0; i < NUM; i++) begin
      alloc_hit[i]   = alloc_vld    && (alloc_idx    == IDX_W'(i));
      wb6_raw[i]     = pipe6_wb_vld && (pipe6_wb_idx == IDX_W'(i));
      wb7_raw[i]     = pipe7_wb_vld && (pipe7_wb_idx == IDX_W'(i));
      retire_hit[i]  = retire_vld   && (retire_idx   == IDX_W'(i));
      release_hit[i] = release_vld  && (release_idx  == IDX_W'(i));
      wb6_hit[i]     = wb6_raw[i] && (st_q[i] != FREE) && !flush_vld;
      wb7_hit[i]     = wb7_raw[i] && (st_q[i] != FREE) && !flush_vld && !wb6_hit[i];
    end
  end

  // Interleave the per-entry strobes as {pipe7, pipe6} pairs for the eregs.
  always_comb begin
    x_wb_vld = '0;
    for (int i = 0; i < NUM; i++) begin
      x_wb_vld[2*i]   = wb6_hit[i];
      x_wb_vld[2*i+1] = wb7_hit[i];
    end
  end

  // Per-entry next state. Flush clears speculative entries ahead of any
  // alloc/writeback/retire, but a release of a RET entry still goes through.
  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      st_d[i] = st_q[i];
      case (st_q[i])
        FREE: begin
          if (alloc_hit[i] && !flush_vld) st_d[i] = ALLOC;
        end
        ALLOC: begin
          if (flush_vld)                                 st_d[i] = FREE;
          else if ((wb6_hit[i] || wb7_hit[i]) && retire_hit[i]) st_d[i] = RET;
          else if (wb6_hit[i] || wb7_hit[i])             st_d[i] = WB;
        end
        WB: begin
          if (flush_vld)          st_d[i] = FREE;
          else if (retire_hit[i]) st_d[i] = RET;
        end
        RET: begin
          if (release_hit[i]) st_d[i] = FREE;
        end
        default: st_d[i] = FREE;
      endcase
    end
  end

  // Entry state registers; async reset returns every entry to the pool.
  always_ff @(posedge ereg_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      for (int i = 0; i < NUM; i++) st_q[i] <= FREE;
    end else begin
      for (int i = 0; i < NUM; i++) st_q[i] <= st_d[i];
    end
  end

  // Status vectors decoded directly from the state registers.
  always_comb begin
    free_vec              = '0;
    x_retired_released_wb = '0;
    for (int i = 0; i < NUM; i++) begin
      free_vec[i]              = (st_q[i] == FREE);
      x_retired_released_wb[i] = (st_q[i] == RET);
    end
  end

  // Population count of free entries.
  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < NUM; i++) begin
      free_cnt = free_cnt + {{IDX_W{1'b0}}, free_vec[i]};
    end
  end

  // Fold of the entries leaving RET this cycle, and the OR of all ereg
  // outputs (non-RET eregs gate their own output to zero).
  always_comb begin
    fold    = '0;
    dout_or = '0;
    for (int i = 0; i < NUM; i++) begin
      dout_or = dout_or | ereg_acc_dout[6*i +: 6];
      if (release_hit[i] && (st_q[i] == RET)) fold = fold | ereg_acc_dout[6*i +: 6];
    end
  end

  // Sticky accumulator; a release in the clearing cycle is kept.
  always_ff @(posedge ereg_clk or negedge cpurst_b) begin
    if (!cpurst_b) sticky_q <= '0;
    else           sticky_q <= (acc_clr_vld ? 6'b0 : sticky_q) | fold;
  end

  assign acc_value = sticky_q | dout_or;

`ifdef CT_IDU_EREG_ERR_CHK_EN
  logic err_evt;
  logic err_q;

  // Any request that the state machine drops is a protocol error.
  always_comb begin
    err_evt = pipe6_wb_vld && pipe7_wb_vld && (pipe6_wb_idx == pipe7_wb_idx);
    for (int i = 0; i < NUM; i++) begin
      if (alloc_hit[i] && (st_q[i] != FREE))                    err_evt = 1'b1;
      if ((wb6_raw[i] || wb7_raw[i]) && (st_q[i] == FREE))      err_evt = 1'b1;
      if (retire_hit[i] && ((st_q[i] == FREE) ||
          ((st_q[i] == ALLOC) && !(wb6_raw[i] || wb7_raw[i])))) err_evt = 1'b1;
      if (release_hit[i] && (st_q[i] != RET))                   err_evt = 1'b1;
    end
  end

  // Error flag holds until reset.
  always_ff @(posedge ereg_clk or negedge cpurst_b) begin
    if (!cpurst_b)    err_q <= 1'b0;
    else if (err_evt) err_q <= 1'b1;
  end

  assign ereg_proto_err = err_q;
`endif

endmodule

// File: tb/tb_ct_idu_rf_ereg_ctrl.sv
// Directed bench for ct_idu_rf_ereg_ctrl. Honors CT_IDU_EREG_ERR_CHK_EN.
module tb_ct_idu_rf_ereg_ctrl;
  localparam int NUM   = 16;
  localparam int IDX_W = 4;

  logic               ereg_clk;
  logic               cpurst_b;
  logic               alloc_vld;
  logic [IDX_W-1:0]   alloc_idx;
  logic               pipe6_wb_vld;
  logic [IDX_W-1:0]   pipe6_wb_idx;
  logic               pipe7_wb_vld;
  logic [IDX_W-1:0]   pipe7_wb_idx;
  logic               retire_vld;
  logic [IDX_W-1:0]   retire_idx;
  logic               release_vld;
  logic [IDX_W-1:0]   release_idx;
  logic               flush_vld;
  logic               acc_clr_vld;
  logic [6*NUM-1:0]   ereg_acc_dout;
  logic [2*NUM-1:0]   x_wb_vld;
  logic [NUM-1:0]     x_retired_released_wb;
  logic [NUM-1:0]     free_vec;
  logic [IDX_W:0]     free_cnt;
  logic [5:0]         acc_value;
`ifdef CT_IDU_EREG_ERR_CHK_EN
  logic               ereg_proto_err;
`endif

  int checks   = 0;
  int failures = 0;

  ct_idu_rf_ereg_ctrl #(.NUM(NUM), .IDX_W(IDX_W)) dut (
    .ereg_clk              (ereg_clk),
    .cpurst_b              (cpurst_b),
    .alloc_vld             (alloc_vld),
    .alloc_idx             (alloc_idx),
    .pipe6_wb_vld          (pipe6_wb_vld),
    .pipe6_wb_idx          (pipe6_wb_idx),
    .pipe7_wb_vld          (pipe7_wb_vld),
    .pipe7_wb_idx          (pipe7_wb_idx),
    .retire_vld            (retire_vld),
    .retire_idx            (retire_idx),
    .release_vld           (release_vld),
    .release_idx           (release_idx),
    .flush_vld             (flush_vld),
    .acc_clr_vld           (acc_clr_vld),
    .ereg_acc_dout         (ereg_acc_dout),
    .x_wb_vld              (x_wb_vld),
    .x_retired_released_wb (x_retired_released_wb),
    .free_vec              (free_vec),
    .free_cnt              (free_cnt),
`ifdef CT_IDU_EREG_ERR_CHK_EN
    .ereg_proto_err        (ereg_proto_err),
`endif
    .acc_value             (acc_value)
  );

  initial ereg_clk = 1'b0;
  always #5 ereg_clk = ~ereg_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alloc_vld    = 1'b0; alloc_idx    = '0;
    pipe6_wb_vld = 1'b0; pipe6_wb_idx = '0;
    pipe7_wb_vld = 1'b0; pipe7_wb_idx = '0;
    retire_vld   = 1'b0; retire_idx   = '0;
    release_vld  = 1'b0; release_idx  = '0;
    flush_vld    = 1'b0;
    acc_clr_vld  = 1'b0;
  endtask

  task automatic cyc();
    @(posedge ereg_clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    ereg_acc_dout = '0;
    cpurst_b = 1'b0;
    #2;
    chk("rst_free_vec", 64'(free_vec), 64'hFFFF);
    chk("rst_free_cnt", 64'(free_cnt), 64'd16);
    chk("rst_wb_vld",   64'(x_wb_vld), 64'h0);
    chk("rst_ret",      64'(x_retired_released_wb), 64'h0);
    chk("rst_acc",      64'(acc_value), 64'h0);
    #10 cpurst_b = 1'b1;
    cyc();

    // alloc idx3
    alloc_vld = 1'b1; alloc_idx = 4'd3;
    cyc();
    chk("alloc3_free_vec", 64'(free_vec), 64'hFFF7);
    chk("alloc3_free_cnt", 64'(free_cnt), 64'd15);

    // pipe6 writeback idx3, strobe same cycle
    pipe6_wb_vld = 1'b1; pipe6_wb_idx = 4'd3;
    #1 chk("wb6_idx3_strobe", 64'(x_wb_vld), 64'h40);
    cyc();

    // retire idx3 (WB -> RET)
    retire_vld = 1'b1; retire_idx = 4'd3;
    cyc();
    chk("ret3_flag", 64'(x_retired_released_wb), 64'h0008);
`ifdef CT_IDU_EREG_ERR_CHK_EN
    chk("err_clean", 64'(ereg_proto_err), 64'h0);
`endif

    // release and alloc of idx3 in the same cycle: release wins
    release_vld = 1'b1; release_idx = 4'd3;
    alloc_vld   = 1'b1; alloc_idx   = 4'd3;
    cyc();
    chk("rel_alloc3_free", 64'(free_vec), 64'hFFFF);
    chk("rel_alloc3_ret",  64'(x_retired_released_wb), 64'h0);
`ifdef CT_IDU_EREG_ERR_CHK_EN
    chk("err_alloc_nonfree", 64'(ereg_proto_err), 64'h1);
`endif

    // writeback to a FREE entry produces no strobe
    pipe6_wb_vld = 1'b1; pipe6_wb_idx = 4'd9;
    #1 chk("wb_to_free", 64'(x_wb_vld), 64'h0);
    cyc();

    // alloc 5, then retire with no writeback is ignored
    alloc_vld = 1'b1; alloc_idx = 4'd5;
    cyc();
    retire_vld = 1'b1; retire_idx = 4'd5;
    cyc();
    chk("ret_alloc_ignored", 64'(x_retired_released_wb), 64'h0);
    chk("alloc5_free_vec",   64'(free_vec), 64'hFFDF);

    // pipe7 writeback idx5 then retire
    pipe7_wb_vld = 1'b1; pipe7_wb_idx = 4'd5;
    #1 chk("wb7_idx5_strobe", 64'(x_wb_vld), 64'h800);
    cyc();
    retire_vld = 1'b1; retire_idx = 4'd5;
    cyc();
    chk("ret5_flag", 64'(x_retired_released_wb), 64'h0020);
    ereg_acc_dout[35:30] = 6'h21;
    #1 chk("acc_live_ret5", 64'(acc_value), 64'h21);

    // release 5 folds its value into the sticky accumulator
    release_vld = 1'b1; release_idx = 4'd5;
    cyc();
    ereg_acc_dout = '0;
    #1;
    chk("rel5_free_vec", 64'(free_vec), 64'hFFFF);
    chk("rel5_sticky",   64'(acc_value), 64'h21);
    acc_clr_vld = 1'b1;
    cyc();
    chk("acc_cleared", 64'(acc_value), 64'h0);

    // build 1=ALLOC, 2=WB, 4=RET (4 uses same-cycle wb+retire from ALLOC)
    alloc_vld = 1'b1; alloc_idx = 4'd1;
    cyc();
    alloc_vld = 1'b1; alloc_idx = 4'd2;
    cyc();
    alloc_vld = 1'b1; alloc_idx = 4'd4;
    pipe6_wb_vld = 1'b1; pipe6_wb_idx = 4'd2;
    cyc();
    pipe6_wb_vld = 1'b1; pipe6_wb_idx = 4'd4;
    retire_vld   = 1'b1; retire_idx   = 4'd4;
    cyc();
    chk("pre_flush_free", 64'(free_vec), 64'hFFE9);
    chk("pre_flush_ret",  64'(x_retired_released_wb), 64'h0010);

    // flush with pipe7 writeback to 2
    flush_vld = 1'b1;
    pipe7_wb_vld = 1'b1; pipe7_wb_idx = 4'd2;
    #1 chk("flush_kills_wb", 64'(x_wb_vld), 64'h0);
    cyc();
    chk("flush_free_vec", 64'(free_vec), 64'hFFEF);
    chk("flush_free_cnt", 64'(free_cnt), 64'd15);
    chk("flush_keeps_ret", 64'(x_retired_released_wb), 64'h0010);

    // release 4 and also clear in the same cycle: release survives
    ereg_acc_dout[29:24] = 6'h0C;
    release_vld = 1'b1; release_idx = 4'd4;
    acc_clr_vld = 1'b1;
    cyc();
    ereg_acc_dout = '0;
    #1 chk("rel_survives_clr", 64'(acc_value), 64'h0C);

    // reset pulse between scenarios
    cpurst_b = 1'b0;
    #1;
    chk("mid_rst_acc", 64'(acc_value), 64'h0);
    cpurst_b = 1'b1;
    cyc();

    // both pipes target idx7
    alloc_vld = 1'b1; alloc_idx = 4'd7;
    cyc();
`ifdef CT_IDU_EREG_ERR_CHK_EN
    chk("err_after_rst", 64'(ereg_proto_err), 64'h0);
`endif
    pipe6_wb_vld = 1'b1; pipe6_wb_idx = 4'd7;
    pipe7_wb_vld = 1'b1; pipe7_wb_idx = 4'd7;
    #1 chk("dual_wb_idx7", 64'(x_wb_vld), 64'h4000);
    cyc();
`ifdef CT_IDU_EREG_ERR_CHK_EN
    chk("err_dual_wb", 64'(ereg_proto_err), 64'h1);
`endif

    // allocate everything
    for (int i = 0; i < NUM; i++) begin
      alloc_vld = 1'b1; alloc_idx = 4'(i);
      cyc();
    end
    chk("full_free_cnt", 64'(free_cnt), 64'd0);
    chk("full_free_vec", 64'(free_vec), 64'h0);
    alloc_vld = 1'b1; alloc_idx = 4'd0;
    cyc();
    chk("alloc17_ignored", 64'(free_cnt), 64'd0);

    // async reset mid-operation with a writeback still requested
    pipe6_wb_vld = 1'b1; pipe6_wb_idx = 4'd0;
    #1 chk("wb_before_rst", 64'(x_wb_vld), 64'h1);
    cpurst_b = 1'b0;
    #1;
    chk("async_rst_free_vec", 64'(free_vec), 64'hFFFF);
    chk("async_rst_free_cnt", 64'(free_cnt), 64'd16);
    chk("async_rst_wb_vld",   64'(x_wb_vld), 64'h0);
    chk("async_rst_ret",      64'(x_retired_released_wb), 64'h0);
    chk("async_rst_acc",      64'(acc_value), 64'h0);
`ifdef CT_IDU_EREG_ERR_CHK_EN
    chk("async_rst_err",      64'(ereg_proto_err), 64'h0);
`endif
    cpurst_b = 1'b1;
    idle();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
